vram_dma_m: RTL and testbench



---
 rtl/vram_dma_m.sv | 175 +++++++++++++++++
 tb/tb_vram_dma_m.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dma_m.sv
// -----------------------------------------------------------------------------
// vram_dma_m
//
// Sprite-table DMA engine. The CPU writes a source page number into the DMA
// register. At the next vblank the block halts the 6502, copies LENGTH bytes
// from {page, index} in CPU address space into VRAM starting at OAM_BASE, and
// then releases the CPU. It owns the system address bus and the VRAM write
// port only while a transfer is in progress.
//
// Parameters
//   LENGTH       bytes per transfer, 1..256
//   OAM_BASE     first VRAM (gpu-relative) destination address
//   HALT_CYCLES  cycles RDY is held low before the first bus read, 1..7
//
// Ports
//   cpu_clk            sole clock, rising edge
//   rst_B              asynchronous active-low reset
//   SELECT_dma         address decode hit on the DMA register
//   write_enable       active-high CPU write
//   data_in[7:0]       CPU write data (source page)
//   in_vblank          GPU vblank flag, synchronous to cpu_clk
//   dma_read_data[7:0] bus read data while the DMA drives the bus
//   cpu_rdy            to 6502 RDY, low halts the CPU
//   dma_active         high in every state except IDLE
//   dma_pending        request latched, waiting for vblank
//   dma_drive_address  top level muxes dma_address onto the bus as a read
//   dma_address[15:0]  {page, index}
//   vram_write         one-cycle VRAM write strobe
//   vram_address[11:0] OAM_BASE + index, 12-bit wrap
//   vram_data[7:0]     byte captured from the bus read
//   dbg_state[2:0]     current FSM state, for observation only
//
// Handshake: the register write is a single-cycle strobe (SELECT_dma &&
// write_enable) with no back-pressure; it is accepted only in IDLE and is
// silently dropped otherwise. Toward the CPU, cpu_rdy low means "bus owned
// by DMA"; it drops on entry to HALT and rises on entry to IDLE.
// -----------------------------------------------------------------------------
module vram_dma_m #(
  parameter int          LENGTH      = 256,
  parameter logic [11:0] OAM_BASE    = 12'h800,
  parameter int          HALT_CYCLES = 2
) (
  input  logic        cpu_clk,
  input  logic        rst_B,
  input  logic        SELECT_dma,
  input  logic        write_enable,
  input  logic [7:0]  data_in,
  input  logic        in_vblank,
  input  logic [7:0]  dma_read_data,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic        dma_pending,
  output logic        dma_drive_address,
  output logic [15:0] dma_address,
  output logic        vram_write,
  output logic [11:0] vram_address,
  output logic [7:0]  vram_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [8:0] LAST_INDEX = 9'(LENGTH - 1);
  localparam logic [2:0] HALT_LAST  = 3'(HALT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  page_q;
  logic        pending_q;
  logic [8:0]  index_q;
  logic [2:0]  halt_cnt_q;
  logic        drive_q;
  logic        vwr_q;
  logic [15:0] addr_q;
  logic [11:0] vaddr_q;
  logic [7:0]  vdata_q;

  logic        reg_wr;
  logic [8:0]  index_inc;

  assign reg_wr    = SELECT_dma && write_enable;
  assign index_inc = index_q + 9'd1;

  // Single FSM process. Strobe-type outputs (drive, write) default low every
  // cycle and are raised on the edge that enters READ / WRITE respectively,
  // so they are registered and can never overlap or repeat back to back.
  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) begin
      state_q    <= IDLE;
      page_q     <= 8'd0;
      pending_q  <= 1'b0;
      index_q    <= 9'd0;
      halt_cnt_q <= 3'd0;
      drive_q    <= 1'b0;
      vwr_q      <= 1'b0;
      addr_q     <= 16'd0;
      vaddr_q    <= 12'd0;
      vdata_q    <= 8'd0;
    end else begin
      drive_q <= 1'b0;
      vwr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A write always updates the page while idle, even on the edge that
          // starts a transfer; the first bus read is several cycles away.
          if (reg_wr) begin
            page_q <= data_in;
          end
          if (pending_q && in_vblank) begin
            state_q    <= HALT;
            pending_q  <= 1'b0;
            index_q    <= 9'd0;
            halt_cnt_q <= 3'd0;
          end else if (reg_wr) begin
            pending_q <= 1'b1;
          end
        end

        HALT: begin
          if (halt_cnt_q == HALT_LAST) begin
            state_q <= READ;
            drive_q <= 1'b1;
            addr_q  <= {page_q, index_q[7:0]};
          end else begin
            halt_cnt_q <= halt_cnt_q + 3'd1;
          end
        end

        READ: begin
          state_q <= WRITE;
          vdata_q <= dma_read_data;
          vwr_q   <= 1'b1;
          vaddr_q <= OAM_BASE + {3'b000, index_q};
        end

        WRITE: begin
          if (index_q == LAST_INDEX) begin
            state_q <= DONE;
          end else begin
            state_q <= READ;
            index_q <= index_inc;
            drive_q <= 1'b1;
            // Only the low byte reaches the bus; index never carries into page.
            addr_q  <= {page_q, index_inc[7:0]};
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded straight from the registered state.
  assign cpu_rdy           = (state_q == IDLE);
  assign dma_active        = (state_q != IDLE);
  assign dma_pending       = pending_q;
  assign dma_drive_address = drive_q;
  assign dma_address       = addr_q;
  assign vram_write        = vwr_q;
  assign vram_address      = vaddr_q;
  assign vram_data         = vdata_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_vram_dma_m.sv
// -----------------------------------------------------------------------------
// tb_vram_dma_m
//
// Bench for vram_dma_m. Instance A uses default parameters; instance B uses
// LENGTH=4, OAM_BASE=12'hFFE to exercise destination wrap. A shared 64 KiB
// memory array answers DMA bus reads. Expected VRAM writes are generated from
// the copy rule (dest = base + i, data = mem[{page, i}]) into a queue and
// consumed by a monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vram_dma_m;

  localparam int          HALT   = 2;
  localparam int          LEN_A  = 256;
  localparam int          LEN_B  = 4;
  localparam logic [11:0] BASE_A = 12'h800;
  localparam logic [11:0] BASE_B = 12'hFFE;

  // ---------------- clock ----------------
  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- instance A signals ----------------
  logic        a_rst = 1'b0, a_sel = 1'b0, a_we = 1'b0, a_vblank = 1'b0;
  logic [7:0]  a_din = 8'd0;
  logic [7:0]  a_rd;
  logic        a_rdy, a_act, a_pend, a_drv, a_vw;
  logic [15:0] a_addr;
  logic [11:0] a_va;
  logic [7:0]  a_vd;
  logic [2:0]  a_dbg;

  // ---------------- instance B signals ----------------
  logic        b_rst = 1'b0, b_sel = 1'b0, b_we = 1'b0, b_vblank = 1'b0;
  logic [7:0]  b_din = 8'd0;
  logic [7:0]  b_rd;
  logic        b_rdy, b_act, b_pend, b_drv, b_vw;
  logic [15:0] b_addr;
  logic [11:0] b_va;
  logic [7:0]  b_vd;
  logic [2:0]  b_dbg;

  // CPU address space seen by the DMA; junk value when the bus is not driven.
  logic [7:0] mem [0:65535];
  assign a_rd = a_drv ? mem[a_addr] : 8'hEE;
  assign b_rd = b_drv ? mem[b_addr] : 8'hEE;

  vram_dma_m u_dut_a (
    .cpu_clk(cpu_clk), .rst_B(a_rst), .SELECT_dma(a_sel), .write_enable(a_we),
    .data_in(a_din), .in_vblank(a_vblank), .dma_read_data(a_rd),
    .cpu_rdy(a_rdy), .dma_active(a_act), .dma_pending(a_pend),
    .dma_drive_address(a_drv), .dma_address(a_addr), .vram_write(a_vw),
    .vram_address(a_va), .vram_data(a_vd), .dbg_state(a_dbg)
  );

  vram_dma_m #(.LENGTH(LEN_B), .OAM_BASE(BASE_B), .HALT_CYCLES(HALT)) u_dut_b (
    .cpu_clk(cpu_clk), .rst_B(b_rst), .SELECT_dma(b_sel), .write_enable(b_we),
    .data_in(b_din), .in_vblank(b_vblank), .dma_read_data(b_rd),
    .cpu_rdy(b_rdy), .dma_active(b_act), .dma_pending(b_pend),
    .dma_drive_address(b_drv), .dma_address(b_addr), .vram_write(b_vw),
    .vram_address(b_va), .vram_data(b_vd), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  logic [19:0] exp_b_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int   a_wcount = 0, a_low = 0, a_last_low = 0;
  logic a_prev_vw = 1'b0;
  logic [19:0] a_e;
  int   b_wcount = 0, b_low = 0, b_last_low = 0;
  logic b_prev_vw = 1'b0;
  logic [19:0] b_e;

  // Reference model of the register: page and pending flag.
  logic [7:0] m_page = 8'd0;
  bit         m_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit to_b, input logic [7:0] page, input int len,
                          input logic [11:0] base);
    logic [11:0] va;
    logic [7:0]  off;
    for (int i = 0; i < len; i++) begin
      va  = base + 12'(i);
      off = 8'(i);
      if (to_b) exp_b_q.push_back({va, mem[{page, off}]});
      else      exp_q.push_back({va, mem[{page, off}]});
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge cpu_clk) begin
    if (!a_rst) begin
      a_low     = 0;
      a_prev_vw = 1'b0;
    end else begin
      check("a_excl", a_vw && a_drv, 0);
      check("a_vw_b2b", a_vw && a_prev_vw, 0);
      a_prev_vw = a_vw;
      if (a_vw) begin
        a_wcount++;
        if (exp_q.size() == 0) check("a_unexp_wr", exp_q.size(), 1);
        else begin
          a_e = exp_q.pop_front();
          check("a_wr_addr", a_va, a_e[19:8]);
          check("a_wr_data", a_vd, a_e[7:0]);
        end
      end
      if (!a_rdy) a_low++;
      else if (a_low != 0) begin
        a_last_low = a_low;
        a_low      = 0;
      end
    end
  end

  always @(negedge cpu_clk) begin
    if (!b_rst) begin
      b_low     = 0;
      b_prev_vw = 1'b0;
    end else begin
      check("b_excl", b_vw && b_drv, 0);
      check("b_vw_b2b", b_vw && b_prev_vw, 0);
      b_prev_vw = b_vw;
      if (b_vw) begin
        b_wcount++;
        if (exp_b_q.size() == 0) check("b_unexp_wr", exp_b_q.size(), 1);
        else begin
          b_e = exp_b_q.pop_front();
          check("b_wr_addr", b_va, b_e[19:8]);
          check("b_wr_data", b_vd, b_e[7:0]);
        end
      end
      if (!b_rdy) b_low++;
      else if (b_low != 0) begin
        b_last_low = b_low;
        b_low      = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_check_reset();
    check("rst_cpu_rdy", a_rdy, 1);
    check("rst_dma_active", a_act, 0);
    check("rst_dma_pending", a_pend, 0);
    check("rst_drive", a_drv, 0);
    check("rst_dma_address", a_addr, 0);
    check("rst_vram_write", a_vw, 0);
    check("rst_vram_address", a_va, 0);
    check("rst_vram_data", a_vd, 0);
  endtask

  task automatic a_write(input logic [7:0] p);
    @(negedge cpu_clk);
    a_sel = 1'b1; a_we = 1'b1; a_din = p;
    @(negedge cpu_clk);
    a_sel = 1'b0; a_we = 1'b0;
    m_page    = p;
    m_pending = 1'b1;
  endtask

  task automatic a_abort();
    a_rst = 1'b0;
    #1;
    a_check_reset();
    exp_q.delete();
    a_vblank  = 1'b0;
    m_pending = 1'b0;
    repeat (3) begin
      @(negedge cpu_clk);
      check("abort_vram_write", a_vw, 0);
      check("abort_cpu_rdy", a_rdy, 1);
    end
    a_rst = 1'b1;
    repeat (20) begin
      @(negedge cpu_clk);
      check("post_abort_rdy", a_rdy, 1);
      check("post_abort_pending", a_pend, 0);
      check("post_abort_active", a_act, 0);
    end
  endtask

  // simul: register write and vblank rise in the same cycle.
  // busy_at/abort_at: byte count at which to write 0x07 / pulse reset (-1 = off).
  task automatic a_run(input bit simul, input logic [7:0] sp, input int busy_at,
                       input int abort_at);
    int n, rdy_at, base;
    bit busy_done, aborted;
    @(negedge cpu_clk);
    base = a_wcount;
    if (simul) begin
      a_sel = 1'b1; a_we = 1'b1; a_din = sp;
      m_page = sp;
    end
    a_vblank = 1'b1;
    push_exp(1'b0, m_page, LEN_A, BASE_A);
    m_pending = 1'b0;
    n = 0; rdy_at = 0; busy_done = 1'b0; aborted = 1'b0;
    while (!a_drv && n < 50) begin
      @(negedge cpu_clk);
      n++;
      if (n == 1 && simul) begin
        a_sel = 1'b0; a_we = 1'b0;
        check("simul_pending", a_pend, 1);
        check("simul_rdy", a_rdy, 1);
      end
      if (!a_rdy && rdy_at == 0) rdy_at = n;
    end
    check("halt_latency", rdy_at, simul ? 2 : 1);
    check("read_latency", n, HALT + (simul ? 2 : 1));
    check("first_dma_address", a_addr, {m_page, 8'h00});
    if (busy_at < 0) a_vblank = 1'b0;  // vblank may fall mid-transfer
    n = 0;
    while (!(a_rdy && !a_act) && n < 3000 && !aborted) begin
      @(negedge cpu_clk);
      n++;
      if (busy_at >= 0 && !busy_done && (a_wcount - base) >= busy_at) begin
        a_sel = 1'b1; a_we = 1'b1; a_din = 8'h07;
        @(negedge cpu_clk);
        a_sel = 1'b0; a_we = 1'b0;
        n++;
        busy_done = 1'b1;
      end
      if (abort_at >= 0 && (a_wcount - base) >= abort_at) begin
        a_abort();
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      @(negedge cpu_clk);
      check("done_in_budget", n < 3000, 1);
      check("rdy_low_cycles", a_last_low, HALT + 2 * LEN_A + 1);
      check("write_count", a_wcount - base, LEN_A);
      check("exp_q_empty", exp_q.size(), 0);
      if (busy_at >= 0) begin
        repeat (40) begin
          @(negedge cpu_clk);
          check("busy_no_pending", a_pend, 0);
          check("busy_no_rerun", a_rdy, 1);
        end
        a_vblank = 1'b0;
      end
    end
  endtask

  task automatic b_run(input logic [7:0] p);
    int n, base;
    @(negedge cpu_clk);
    b_sel = 1'b1; b_we = 1'b1; b_din = p;
    @(negedge cpu_clk);
    b_sel = 1'b0; b_we = 1'b0;
    check("b_pending", b_pend, 1);
    base = b_wcount;
    push_exp(1'b1, p, LEN_B, BASE_B);
    b_vblank = 1'b1;
    n = 0;
    while (!((b_wcount - base) >= LEN_B && b_rdy) && n < 200) begin
      @(negedge cpu_clk);
      n++;
    end
    @(negedge cpu_clk);
    b_vblank = 1'b0;
    check("b_done_in_budget", n < 200, 1);
    check("b_rdy_low_cycles", b_last_low, HALT + 2 * LEN_B + 1);
    check("b_write_count", b_wcount - base, LEN_B);
    check("b_exp_empty", exp_b_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] p1, p2;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0700 + i] = ~(8'(i) ^ 8'h5A);
    end

    repeat (3) @(negedge cpu_clk);
    a_check_reset();
    check("b_rst_rdy", b_rdy, 1);
    check("b_rst_active", b_act, 0);
    check("b_rst_vram_write", b_vw, 0);
    a_rst = 1'b1;
    b_rst = 1'b1;
    @(negedge cpu_clk);

    // Basic copy of page 0x02, with an ignored write of 0x07 mid-transfer.
    a_write(8'h02);
    a_run(1'b0, 8'h00, 64, -1);

    // Deferred start: request waits while vblank is low.
    a_write(8'h03);
    repeat (100) begin
      @(negedge cpu_clk);
      check("defer_pending", a_pend, 1);
      check("defer_active", a_act, 0);
      check("defer_rdy", a_rdy, 1);
    end
    a_run(1'b0, 8'h00, -1, -1);

    // Register write coincident with vblank rise.
    a_run(1'b1, 8'h04, -1, -1);

    // Random pages; second write while pending overwrites the first.
    for (int k = 0; k < 3; k++) begin
      p1 = 8'($urandom_range(0, 255));
      p2 = p1 ^ 8'($urandom_range(1, 255));
      a_write(p1);
      repeat ($urandom_range(1, 8)) @(negedge cpu_clk);
      a_write(p2);
      repeat ($urandom_range(0, 6)) @(negedge cpu_clk);
      a_run(1'b0, 8'h00, -1, -1);
    end

    // Reset abort at index 0x80.
    a_write(8'($urandom_range(0, 255)));
    a_run(1'b0, 8'h00, -1, 128);

    // Short transfer with destination wrap.
    b_run(8'($urandom_range(0, 255)));
    b_run(8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
